// File: rtl/bus_pkg.sv
// Shared types and helpers for the common-bus arbiter.
// Holds the FSM state encoding, mode codes and a one-hot helper.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    LOCKED
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int MAXSRC = 16;

  function automatic logic [MAXSRC-1:0] onehot(
    input logic [3:0] idx
  );
    return MAXSRC'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester at or after ptr, modulo NSRC.
// Purely combinational; the owner keeps the pointer register.
module rr_pick #(
  parameter  int NSRC = 8,
  localparam int SELW = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] win_idx
);

  int p;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    p       = 0;
    for (int i = 0; i < NSRC; i++) begin
      p = int'(ptr) + i;
      if (p >= NSRC) p = p - NSRC;
      if (!found && req[p]) begin
        found   = 1'b1;
        win_idx = SELW'(p);
      end
    end
  end

endmodule

// File: rtl/common_bus_arbiter.sv
// Registered common-bus transfer unit: direct select or round-robin
// arbitration with per-source lock, one registered bus word per cycle.
module common_bus_arbiter
  import bus_pkg::*;
#(
  parameter  int W    = 16,
  parameter  int NSRC = 8,
  localparam int SELW = $clog2(NSRC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic              sel_valid,
  input  logic [NSRC-1:0]   req,
  input  logic [NSRC-1:0]   lock,
  input  logic [NSRC*W-1:0] src_data,
  output logic [W-1:0]      bus_out,
  output logic              bus_valid,
  output logic [SELW-1:0]   bus_src,
  output logic [NSRC-1:0]   gnt,
  output logic              sel_err
);

  localparam logic [SELW:0]   NSRC_W = (SELW+1)'(NSRC);
  localparam logic [SELW-1:0] LAST   = SELW'(NSRC - 1);

  state_t          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [W-1:0]    bus_out_q, bus_out_d;
  logic            bus_valid_q, bus_valid_d;
  logic [SELW-1:0] bus_src_q, bus_src_d;
  logic [NSRC-1:0] gnt_q, gnt_d;
  logic            sel_err_q, sel_err_d;

  logic            found;
  logic [SELW-1:0] win_idx;
  logic            do_arb;

  rr_pick #(.NSRC(NSRC)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .found   (found),
    .win_idx (win_idx)
  );

  // Loop-compare mux: an index past NSRC-1 yields zero, never X.
  function automatic logic [W-1:0] word_at(
    input logic [SELW-1:0] i
  );
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < NSRC; k++)
      if (int'(i) == k) r = src_data[k*W +: W];
    return r;
  endfunction

  function automatic logic [NSRC-1:0] oh_n(
    input logic [SELW-1:0] i
  );
    return NSRC'(onehot(4'(i)));
  endfunction

  always_comb begin
    state_d     = IDLE;
    ptr_d       = ptr_q;
    bus_out_d   = bus_out_q;
    bus_valid_d = 1'b0;
    bus_src_d   = bus_src_q;
    gnt_d       = '0;
    sel_err_d   = 1'b0;
    do_arb      = 1'b0;

    unique case (state_q)
      LOCKED: begin
        if (req[bus_src_q] && lock[bus_src_q]) begin
          state_d     = LOCKED;
          bus_out_d   = word_at(bus_src_q);
          bus_valid_d = 1'b1;
          gnt_d       = gnt_q;
        end else begin
          do_arb = 1'b1;
        end
      end
      default: begin
        if (mode == MODE_RR) begin
          do_arb = 1'b1;
        end else if (sel_valid) begin
          if ({1'b0, sel} >= NSRC_W) begin
            sel_err_d = 1'b1;
          end else begin
            state_d     = XFER;
            bus_out_d   = word_at(sel);
            bus_src_d   = sel;
            gnt_d       = oh_n(sel);
            bus_valid_d = 1'b1;
          end
        end
      end
    endcase

    if (do_arb && found) begin
      state_d     = lock[win_idx] ? LOCKED : XFER;
      bus_out_d   = word_at(win_idx);
      bus_src_d   = win_idx;
      gnt_d       = oh_n(win_idx);
      bus_valid_d = 1'b1;
      ptr_d       = (win_idx == LAST) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      bus_src_q   <= '0;
      gnt_q       <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
      bus_src_q   <= bus_src_d;
      gnt_q       <= gnt_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus_out   = bus_out_q;
  assign bus_valid = bus_valid_q;
  assign bus_src   = bus_src_q;
  assign gnt       = gnt_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_common_bus_arbiter.sv
// Scoreboard bench for common_bus_arbiter with W=16, NSRC=6.
// Sources: 0=AR 1=PC 2=DR 3=AC 4=IR 5=RAM.
module tb_common_bus_arbiter;

  localparam int W    = 16;
  localparam int NSRC = 6;
  localparam int SELW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic [SELW-1:0]   sel;
  logic              sel_valid;
  logic [NSRC-1:0]   req;
  logic [NSRC-1:0]   lock;
  logic [NSRC*W-1:0] src_data;
  logic [W-1:0]      bus_out;
  logic              bus_valid;
  logic [SELW-1:0]   bus_src;
  logic [NSRC-1:0]   gnt;
  logic              sel_err;

  logic [W-1:0] ar, pc, dr, ac, ir, ram;
  assign src_data = {ram, ir, ac, dr, pc, ar};

  always #5 clk = ~clk;

  common_bus_arbiter #(.W(W), .NSRC(NSRC)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .sel_valid (sel_valid),
    .req       (req),
    .lock      (lock),
    .src_data  (src_data),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .bus_src   (bus_src),
    .gnt       (gnt),
    .sel_err   (sel_err)
  );

  typedef struct {
    string           tag;
    logic [W-1:0]    out;
    logic            v;
    logic [SELW-1:0] src;
    logic [NSRC-1:0] g;
    logic            e;
  } exp_t;

  exp_t exp_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  // Push the expected result of the edge following the current negedge.
  task automatic expect_next(input string tag, input logic [W-1:0] o,
                             input logic v, input logic [SELW-1:0] s,
                             input logic [NSRC-1:0] g, input logic e);
    exp_t x;
    x.tag = tag; x.out = o; x.v = v; x.src = s; x.g = g; x.e = e;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_run++;
        if (bus_out !== x.out || bus_valid !== x.v || bus_src !== x.src ||
            gnt !== x.g || sel_err !== x.e) begin
          n_fail++;
          $display("FAIL %s: got out=%h v=%b src=%0d gnt=%b err=%b want out=%h v=%b src=%0d gnt=%b err=%b",
                   x.tag, bus_out, bus_valid, bus_src, gnt, sel_err,
                   x.out, x.v, x.src, x.g, x.e);
        end
      end
    end
  end

  initial begin
    ar = 16'h1111; pc = 16'h2222; dr = 16'h3333;
    ac = 16'hBEEF; ir = 16'h5555; ram = 16'h6666;
    rst = 1'b1; mode = 1'b1; sel = '0; sel_valid = 1'b0;
    req = 6'h3F; lock = '0;
    @(negedge clk);

    expect_next("rst0", 16'h0, 0, 0, 6'b0, 0);
    expect_next("rst1", 16'h0, 0, 0, 6'b0, 0);
    rst = 1'b0;
    expect_next("first_rr", 16'h1111, 1, 0, 6'b000001, 0);

    mode = 1'b0; sel = 3'd3; sel_valid = 1'b1;
    expect_next("direct_ac", 16'hBEEF, 1, 3, 6'b001000, 0);
    sel = 3'd6;
    expect_next("sel_oor", 16'hBEEF, 0, 3, 6'b0, 1);
    sel_valid = 1'b0;
    expect_next("sel_err_drop", 16'hBEEF, 0, 3, 6'b0, 0);

    rst = 1'b1;
    expect_next("rst_again", 16'h0, 0, 0, 6'b0, 0);
    rst = 1'b0; mode = 1'b1; req = 6'b100101;
    expect_next("rr0", 16'h1111, 1, 0, 6'b000001, 0);
    expect_next("rr2", 16'h3333, 1, 2, 6'b000100, 0);
    expect_next("rr5", 16'h6666, 1, 5, 6'b100000, 0);
    expect_next("rr_wrap0", 16'h1111, 1, 0, 6'b000001, 0);
    req = 6'b0;
    expect_next("rr_none", 16'h1111, 0, 0, 6'b0, 0);

    req = 6'b000110; lock = 6'b000010; pc = 16'hA001;
    expect_next("lock_a", 16'hA001, 1, 1, 6'b000010, 0);
    pc = 16'hA002;
    expect_next("lock_b", 16'hA002, 1, 1, 6'b000010, 0);
    pc = 16'hA003;
    expect_next("lock_c", 16'hA003, 1, 1, 6'b000010, 0);
    lock = 6'b0;
    expect_next("unlock_dr", 16'h3333, 1, 2, 6'b000100, 0);

    req = 6'b000010; lock = 6'b000010;
    expect_next("relock_pc", 16'hA003, 1, 1, 6'b000010, 0);
    mode = 1'b0; sel = 3'd4; sel_valid = 1'b1; pc = 16'hA004;
    expect_next("mode_ign", 16'hA004, 1, 1, 6'b000010, 0);
    lock = 6'b0;
    expect_next("release_rr", 16'hA004, 1, 1, 6'b000010, 0);
    expect_next("mode_direct", 16'h5555, 1, 4, 6'b010000, 0);

    mode = 1'b1; sel_valid = 1'b0; req = 6'b000001; lock = 6'b000001;
    expect_next("lock_ar", 16'h1111, 1, 0, 6'b000001, 0);
    rst = 1'b1;
    expect_next("rst_locked", 16'h0, 0, 0, 6'b0, 0);
    rst = 1'b0; req = 6'h3F; lock = 6'b0;
    expect_next("after_rst", 16'h1111, 1, 0, 6'b000001, 0);
    req = 6'h3F;
    expect_next("next_pc", 16'hA004, 1, 1, 6'b000010, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/common_bus_arbiter.md
# common_bus_arbiter

Registered, parametrised common-bus transfer unit for the basic-computer datapath. It replaces the fixed 3-bit bus multiplexer with a clocked block that supports N sources of W bits and two modes: direct select (controller-driven) and round-robin arbitration with per-source bus lock. It sits between the register file/RAM outputs and every bus destination. It drives one registered bus word per cycle, together with valid, source index and one-hot grant.

## Interface
- W, 16, bus/data width in bits
- NSRC, 8, number of bus sources (2..16); source k occupies src_data[k*W +: W]
- SELW, $clog2(NSRC), width of sel and bus_src (derived localparam, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = direct select, 1 = round-robin arbitration
- sel  in  SELW  direct-mode source index
- sel_valid  in  1  direct-mode transfer request
- req  in  NSRC  per-source bus requests (arbitration mode)
- lock  in  NSRC  per-source lock; holds grant while asserted with req
- src_data  in  NSRC*W  flattened source words
- bus_out  out  W  registered bus word
- bus_valid  out  1  bus_out carries a transfer this cycle
- bus_src  out  SELW  index of source on bus
- gnt  out  NSRC  one-hot grant, aligned with bus_out
- sel_err  out  1  one-cycle pulse: direct request with sel >= NSRC

## Operation
- States: IDLE, XFER, LOCKED.
- Reset values: bus_out=0, bus_valid=0, bus_src=0, gnt=0, sel_err=0, rr pointer ptr=0, state IDLE.
- Mode 0, from IDLE or XFER:
  - sel_valid with sel<NSRC: bus_out<=src_data[sel], bus_src<=sel, gnt<=1<<sel, bus_valid<=1; go to XFER.
  - sel_valid with sel>=NSRC: no transfer; sel_err pulses 1 cycle; bus_valid<=0; go to IDLE.
  - No sel_valid: bus_valid<=0, gnt<=0; go to IDLE.
  - req/lock are ignored; ptr is unchanged.
- Mode 1, from IDLE or XFER:
  - Winner = first k with req[k]=1, searching ptr, ptr+1, … modulo NSRC.
  - If there is a winner: latch its data/index/grant, bus_valid<=1, ptr<=(winner+1) mod NSRC.
  - If lock[winner]=1 at the grant edge, go to LOCKED; otherwise go to XFER.
  - If req==0: bus_valid<=0, gnt<=0; go to IDLE.
  - sel/sel_valid are ignored.
- LOCKED:
  - While req[g] and lock[g] are both set for the held source g: gnt and bus_src are held, and bus_out re-samples src_data[g] every cycle with bus_valid=1.
  - When either req[g] or lock[g] drops: a normal mode-1 arbitration is performed on that same edge, using ptr (already g+1).
  - mode is ignored while LOCKED. A pending mode change takes effect on the first edge after the lock is released.
- When bus_valid=0, bus_out keeps its last value (no bus-zeroing).
- Bits of src_data for indices >= NSRC do not exist. Out-of-range sel never produces X on bus_out.

## Timing
- Latency: request sampled at edge n appears on bus_out/bus_valid/gnt after edge n, i.e. 1 cycle.
- Throughput: one transfer per cycle, back-to-back, in both modes. No idle bubble between grants.
- Simultaneous requests in mode 1: exactly one grant per cycle; gnt is always one-hot or zero.
- Pointer wrap: with winner=NSRC-1, ptr becomes 0.
- rst asserted mid-transfer or in LOCKED: all outputs return to their reset values at that edge, regardless of req/lock.
- Mode change mid-XFER: the new mode is applied at the next edge with no extra cycle.

## Structure
- Package bus_pkg:
  - state enum {IDLE, XFER, LOCKED}
  - MODE_DIRECT=1'b0, MODE_RR=1'b1
  - function onehot(idx)
- Sub-module rr_pick:
  - Combinational rotating-priority picker.
  - Parameter NSRC; inputs req and ptr; outputs found and win_idx.
  - Instantiated once.
- Top level holds the FSM, ptr register, output registers and the src_data slice mux.

## Test plan
- W=16, NSRC=6 (0=AR, 1=PC, 2=DR, 3=AC, 4=IR, 5=RAM) throughout.
- Reset check: hold rst 2 cycles with req=6'h3F -> bus_valid=0, gnt=0, bus_out=0. Release -> first grant is source 0 (ptr=0).
- Direct mode: mode=0, sel=3, sel_valid=1, AC=16'hBEEF -> next cycle bus_out=BEEF, bus_src=3, gnt=6'b001000. Then sel=6 -> sel_err pulses once, bus_valid=0, bus_out stays BEEF.
- Round-robin: mode=1, req=6'b100101 held 4 cycles -> grants 0, 2, 5, 0 on consecutive cycles (pointer wraps 5->0).
- Lock: req=6'b000110, lock[1]=1 for 3 cycles, PC changes value each cycle -> gnt=000010 for 3 cycles, bus_out tracks PC. Lock drops -> next grant is source 2.
- Reset mid-lock plus mode change: in LOCKED, assert mode=0 -> no effect until lock drops. Assert rst while LOCKED -> outputs zero at that edge and state is IDLE.
